// File: rtl/orv64_magicmem_req_bridge.sv
// orv64_magicmem_req_bridge
//   Feeds the magic-memory OURSBUS target. Core requests are queued in a small FIFO and
//   issued one at a time on the ob_* port; each issued request is held stable until the
//   target pulses ob_resp. The captured read data / error is returned on a valid/ready
//   response channel.
//
// Optional feature: define ORV64_MM_BRIDGE_TIMEOUT_EN to abort an issued request after
//   TIMEOUT_CYCLES cycles without ob_resp (resp_err=1, resp_rdata=0).
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        core request handshake (req_ready = FIFO not full)
//   req_rwn/req_addr/req_wdata request payload (1=read); top 6 addr bits replaced by OB_ID
//   resp_valid/resp_ready      response handshake
//   resp_rdata/resp_err        read data (0 for writes/timeouts) and error
//   ob_req/ob_rwn/ob_addr/ob_wdata  registered request to the target
//   ob_rdata/ob_resp/ob_resp_err    target response, valid with the 1-cycle ob_resp pulse
//   spurious_resp              sticky flag: ob_resp seen while no request was outstanding

module orv64_magicmem_req_bridge #(
   parameter int unsigned PHY_ADDR_WIDTH = 56,
   parameter int unsigned FIFO_DEPTH     = 2,
   parameter logic [5:0]  OB_ID          = 6'h2A,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_rwn,
   input  logic [PHY_ADDR_WIDTH-1:0] req_addr,
   input  logic [63:0]               req_wdata,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [63:0]               resp_rdata,
   output logic                      resp_err,
   output logic                      ob_req,
   output logic                      ob_rwn,
   output logic [PHY_ADDR_WIDTH-1:0] ob_addr,
   output logic [63:0]               ob_wdata,
   input  logic [63:0]               ob_rdata,
   input  logic                      ob_resp,
   input  logic                      ob_resp_err,
   output logic                      spurious_resp
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LowW = PHY_ADDR_WIDTH - 6;
   localparam logic [PtrW:0] FullCnt = FIFO_DEPTH[PtrW:0];

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

   // ---------------------------------------------------------------------------------------
   // Request FIFO. Only the low address bits are stored; the top bits become OB_ID on issue.
   // ---------------------------------------------------------------------------------------
   logic [LowW-1:0] fifo_addr  [FIFO_DEPTH];
   logic [63:0]     fifo_wdata [FIFO_DEPTH];
   logic            fifo_rwn   [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr, rd_ptr;
   logic [PtrW:0]   count;
   logic            full, empty, push, pop;

   assign full      = (count == FullCnt);
   assign empty     = (count == '0);
   // A full FIFO refuses a push even when a pop happens in the same cycle.
   assign req_ready = !full;
   assign push      = req_valid && !full;

   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[PHY_ADDR_WIDTH-1 -: 6];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr]  <= req_addr[LowW-1:0];
         fifo_wdata[wr_ptr] <= req_wdata;
         fifo_rwn[wr_ptr]   <= req_rwn;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Issue FSM
   // ---------------------------------------------------------------------------------------
   state_e                    state_q, state_d;
   logic                      ob_req_d, ob_rwn_d;
   logic [PHY_ADDR_WIDTH-1:0] ob_addr_d;
   logic [63:0]               ob_wdata_d;
   logic                      resp_valid_d, resp_err_d;
   logic [63:0]               resp_rdata_d;
   logic                      spurious_d;
   logic                      timed_out;

`ifdef ORV64_MM_BRIDGE_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

   logic [TmoW-1:0] tmo_cnt;

   // Held at zero outside ISSUE, so it starts from zero on every ISSUE entry.
   always_ff @(posedge clk) begin
      if (rst || state_q != StIssue) tmo_cnt <= '0;
      else                           tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign timed_out = (tmo_cnt == TmoLast);
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign timed_out      = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      pop          = 1'b0;
      ob_req_d     = ob_req;
      ob_rwn_d     = ob_rwn;
      ob_addr_d    = ob_addr;
      ob_wdata_d   = ob_wdata;
      resp_valid_d = resp_valid;
      resp_rdata_d = resp_rdata;
      resp_err_d   = resp_err;
      // Any response pulse without an outstanding request is flagged, never captured.
      spurious_d   = spurious_resp || (ob_resp && state_q != StIssue);

      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop        = 1'b1;
               ob_req_d   = 1'b1;
               ob_rwn_d   = fifo_rwn[rd_ptr];
               ob_addr_d  = {OB_ID, fifo_addr[rd_ptr]};
               ob_wdata_d = fifo_wdata[rd_ptr];
               state_d    = StIssue;
            end
         end
         StIssue: begin
            // ob_resp takes priority over a timeout expiring in the same cycle.
            if (ob_resp) begin
               ob_req_d     = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = ob_rwn ? ob_rdata : 64'h0;
               resp_err_d   = ob_resp_err;
               state_d      = StResp;
            end else if (timed_out) begin
               ob_req_d     = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = 64'h0;
               resp_err_d   = 1'b1;
               state_d      = StResp;
            end
         end
         StResp: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         ob_req        <= 1'b0;
         ob_rwn        <= 1'b0;
         ob_addr       <= '0;
         ob_wdata      <= '0;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         resp_err      <= 1'b0;
         spurious_resp <= 1'b0;
      end else begin
         state_q       <= state_d;
         ob_req        <= ob_req_d;
         ob_rwn        <= ob_rwn_d;
         ob_addr       <= ob_addr_d;
         ob_wdata      <= ob_wdata_d;
         resp_valid    <= resp_valid_d;
         resp_rdata    <= resp_rdata_d;
         resp_err      <= resp_err_d;
         spurious_resp <= spurious_d;
      end
   end

endmodule

// File: tb/tb_orv64_magicmem_req_bridge.sv
// tb_orv64_magicmem_req_bridge
//   Directed bench for orv64_magicmem_req_bridge with a behavioural OURSBUS target and a
//   scoreboard of expected issues / responses. Timeout scenario is built only when
//   ORV64_MM_BRIDGE_TIMEOUT_EN is defined.

module tb_orv64_magicmem_req_bridge;

   localparam int unsigned AW = 56;
   localparam logic [5:0]  ID = 6'h2A;

   typedef struct packed {
      logic          rwn;
      logic [AW-1:0] addr;
      logic [63:0]   wdata;
   } ob_exp_t;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } resp_exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_rwn = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [63:0]   req_wdata = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b1;
   logic [63:0]   resp_rdata;
   logic          resp_err;
   logic          ob_req;
   logic          ob_rwn;
   logic [AW-1:0] ob_addr;
   logic [63:0]   ob_wdata;
   logic [63:0]   ob_rdata = '0;
   logic          ob_resp = 1'b0;
   logic          ob_resp_err = 1'b0;
   logic          spurious_resp;

   int checks = 0;
   int errors = 0;
   int resp_count = 0;

   ob_exp_t   exp_ob_q[$];
   resp_exp_t exp_resp_q[$];

   // Target model controls (written only by the stimulus block).
   logic tgt_en  = 1'b1;
   int   tgt_lat = 3;
   int   inj_req = 0;

   orv64_magicmem_req_bridge #(
      .PHY_ADDR_WIDTH(AW),
      .FIFO_DEPTH    (2),
      .OB_ID         (ID),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rwn      (req_rwn),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .ob_req       (ob_req),
      .ob_rwn       (ob_rwn),
      .ob_addr      (ob_addr),
      .ob_wdata     (ob_wdata),
      .ob_rdata     (ob_rdata),
      .ob_resp      (ob_resp),
      .ob_resp_err  (ob_resp_err),
      .spurious_resp(spurious_resp)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model_rdata(input logic [AW-1:0] a);
      if (a[31:0] == 32'h8000_0010) return 64'hDEAD_BEEF_0123_4567;
      return {8'hC3, a};
   endfunction

   function automatic logic model_err(input logic [AW-1:0] a);
      return (a[7:0] == 8'hEE);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural target: responds tgt_lat cycles after first seeing ob_req, 1-cycle pulse.
   int tgt_cnt = 0;
   int inj_done = 0;
   always begin
      @(posedge clk);
      #1;
      if (ob_resp) begin
         ob_resp     = 1'b0;
         ob_resp_err = 1'b0;
      end else if (inj_req != inj_done) begin
         inj_done    = inj_req;
         ob_resp     = 1'b1;
         ob_rdata    = 64'h5555_AAAA_5555_AAAA;
         ob_resp_err = 1'b1;
      end else if (ob_req && tgt_en && !rst) begin
         tgt_cnt++;
         if (tgt_cnt == tgt_lat) begin
            ob_resp     = 1'b1;
            ob_rdata    = model_rdata(ob_addr);
            ob_resp_err = model_err(ob_addr);
         end
      end
      if (!ob_req) tgt_cnt = 0;
   end

   // Monitors, sampled on the falling edge.
   logic          prev_req = 1'b0, prev_resp = 1'b0, prev_hs = 1'b0;
   logic          prev_rv = 1'b0, prev_rr = 1'b0, prev_err = 1'b0, prev_rwn = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [63:0]   prev_wdata = '0, prev_rdata = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_req  = 1'b0;
         prev_resp = 1'b0;
         prev_hs   = 1'b0;
         prev_rv   = 1'b0;
         prev_rr   = 1'b0;
      end else begin
         if (ob_req && !prev_req) begin
            chk("issue_expected", 64'(exp_ob_q.size() != 0), 64'h1);
            chk("idle_gap_before_issue", 64'(prev_hs), 64'h0);
            if (exp_ob_q.size() != 0) begin
               ob_exp_t e;
               e = exp_ob_q.pop_front();
               chk("issue_rwn", 64'(ob_rwn), 64'(e.rwn));
               chk("issue_addr", 64'(ob_addr), 64'(e.addr));
               chk("issue_wdata", ob_wdata, e.wdata);
            end
         end
         if (ob_req && prev_req) begin
            chk("ob_hold_addr", 64'({ob_rwn, ob_addr}), 64'({prev_rwn, prev_addr}));
            chk("ob_hold_wdata", ob_wdata, prev_wdata);
         end
         if (prev_resp) chk("no_retrigger", 64'(ob_req), 64'h0);
         if (resp_valid && prev_rv && !prev_rr) begin
            chk("resp_hold_rdata", resp_rdata, prev_rdata);
            chk("resp_hold_err", 64'(resp_err), 64'(prev_err));
         end
         if (resp_valid && resp_ready) begin
            chk("resp_expected", 64'(exp_resp_q.size() != 0), 64'h1);
            if (exp_resp_q.size() != 0) begin
               resp_exp_t r;
               r = exp_resp_q.pop_front();
               chk("resp_rdata", resp_rdata, r.rdata);
               chk("resp_err", 64'(resp_err), 64'(r.err));
            end
            resp_count++;
         end
         prev_req   = ob_req;
         prev_resp  = ob_resp;
         prev_hs    = resp_valid && resp_ready;
         prev_rv    = resp_valid;
         prev_rr    = resp_ready;
         prev_err   = resp_err;
         prev_rdata = resp_rdata;
         prev_rwn   = ob_rwn;
         prev_addr  = ob_addr;
         prev_wdata = ob_wdata;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic push_req(input logic rwn, input logic [AW-1:0] addr, input logic [63:0] wd,
                           input logic tmo, output int stalls);
      ob_exp_t   oe;
      resp_exp_t re;
      oe.rwn   = rwn;
      oe.addr  = {ID, addr[AW-7:0]};
      oe.wdata = wd;
      re.rdata = (rwn && !tmo) ? model_rdata(oe.addr) : 64'h0;
      re.err   = tmo ? 1'b1 : model_err(oe.addr);
      exp_ob_q.push_back(oe);
      exp_resp_q.push_back(re);
      req_valid = 1'b1;
      req_rwn   = rwn;
      req_addr  = addr;
      req_wdata = wd;
      stalls    = 0;
      while (!req_ready && stalls < 100) begin
         @(posedge clk);
         #1;
         stalls++;
      end
      chk("push_accepted", 64'(req_ready), 64'h1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_ob_req();
      int n = 0;
      while (!ob_req && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("wait_ob_req", 64'(ob_req), 64'h1);
   endtask

   task automatic wait_resps(input int target);
      int n = 0;
      while (resp_count < target && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("resp_count", 64'(resp_count), 64'(target));
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_ob_req"}, 64'(ob_req), 64'h0);
      chk({tag, "_ob_rwn"}, 64'(ob_rwn), 64'h0);
      chk({tag, "_ob_addr"}, 64'(ob_addr), 64'h0);
      chk({tag, "_ob_wdata"}, ob_wdata, 64'h0);
      chk({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
      chk({tag, "_resp_rdata"}, resp_rdata, 64'h0);
      chk({tag, "_resp_err"}, 64'(resp_err), 64'h0);
      chk({tag, "_spurious"}, 64'(spurious_resp), 64'h0);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'h1);
   endtask

   initial begin
      int st;
      logic [AW-1:0] a;

      // Reset state
      cycles(3);
      check_reset_state("reset");
      rst = 1'b0;
      cycles(2);

      // Single read: latency and issue shape
      push_req(1'b1, 56'h00_0000_8000_0010, 64'h0, 1'b0, st);
      chk("lat_k0_ob_req", 64'(ob_req), 64'h0);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("lat_k%0d_ob_req", k), 64'(ob_req), 64'(k >= 1 && k <= 3));
         chk($sformatf("lat_k%0d_resp_valid", k), 64'(resp_valid), 64'(k == 4));
         if (k == 1) chk("lat_addr_id", 64'(ob_addr[AW-1 -: 6]), 64'(ID));
         if (k == 4) begin
            chk("lat_rdata", resp_rdata, 64'hDEAD_BEEF_0123_4567);
            chk("lat_err", 64'(resp_err), 64'h0);
         end
      end
      wait_resps(1);

      // Three pushes while busy: third stalls until the first pop
      tgt_lat = 6;
      push_req(1'b1, 56'h00_0000_0000_0100, 64'h0, 1'b0, st);
      wait_ob_req();
      push_req(1'b1, 56'h3F_0000_0000_0200, 64'h0, 1'b0, st);
      push_req(1'b0, 56'h00_0000_0000_0300, 64'h1111_2222_3333_4444, 1'b0, st);
      chk("fifo_full_ready", 64'(req_ready), 64'h0);
      push_req(1'b1, 56'h00_0000_0000_04EE, 64'h0, 1'b0, st);
      chk("third_push_stalled", 64'(st > 0), 64'h1);
      wait_resps(5);
      tgt_lat = 3;

      // Response back-pressure for 10 cycles
      resp_ready = 1'b0;
      push_req(1'b1, 56'h00_0000_0000_0500, 64'h0, 1'b0, st);
      push_req(1'b0, 56'h00_0000_0000_0600, 64'hCAFE_F00D_0000_0001, 1'b0, st);
      st = 0;
      while (!resp_valid && st < 50) begin
         @(posedge clk);
         #1;
         st++;
      end
      a = {ID, 50'h500};
      for (int i = 0; i < 10; i++) begin
         chk("bp_resp_valid", 64'(resp_valid), 64'h1);
         chk("bp_resp_rdata", resp_rdata, model_rdata(a));
         chk("bp_no_ob_req", 64'(ob_req), 64'h0);
         @(posedge clk);
         #1;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_resp_valid", 64'(resp_valid), 64'h0);
      chk("bp_release_idle", 64'(ob_req), 64'h0);
      @(posedge clk);
      #1;
      chk("bp_queued_issue", 64'(ob_req), 64'h1);
      wait_resps(7);

      // Spurious response while idle
      cycles(2);
      inj_req++;
      cycles(3);
      chk("spurious_set", 64'(spurious_resp), 64'h1);
      chk("spurious_no_resp", 64'(resp_valid), 64'h0);
      cycles(5);
      chk("spurious_sticky", 64'(spurious_resp), 64'h1);

      // Reset while in ISSUE with two queued
      tgt_en = 1'b0;
      push_req(1'b1, 56'h00_0000_0000_0700, 64'h0, 1'b0, st);
      wait_ob_req();
      push_req(1'b1, 56'h00_0000_0000_0800, 64'h0, 1'b0, st);
      push_req(1'b0, 56'h00_0000_0000_0900, 64'h9, 1'b0, st);
      chk("rst_pre_full", 64'(req_ready), 64'h0);
      chk("rst_pre_issue", 64'(ob_req), 64'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_ob_q.delete();
      exp_resp_q.delete();
      check_reset_state("midrst");
      rst = 1'b0;
      tgt_en = 1'b1;
      cycles(20);
      chk("midrst_no_issue", 64'(ob_req), 64'h0);
      chk("midrst_no_resp", 64'(resp_valid), 64'h0);
      chk("midrst_resp_count", 64'(resp_count), 64'd7);

`ifdef ORV64_MM_BRIDGE_TIMEOUT_EN
      // Target never responds: abort after 8 ISSUE cycles
      tgt_en = 1'b0;
      push_req(1'b1, 56'h00_0000_0000_0A00, 64'h0, 1'b1, st);
      wait_ob_req();
      st = 0;
      while (ob_req && st < 50) begin
         @(posedge clk);
         #1;
         st++;
      end
      chk("tmo_issue_cycles", 64'(st), 64'd8);
      chk("tmo_resp_err", 64'(resp_err), 64'h1);
      chk("tmo_resp_rdata", resp_rdata, 64'h0);
      wait_resps(8);
      chk("tmo_not_spurious", 64'(spurious_resp), 64'h0);
      inj_req++;
      cycles(3);
      chk("tmo_late_spurious", 64'(spurious_resp), 64'h1);
      tgt_en = 1'b1;
`endif

      cycles(3);
      chk("scoreboard_empty", 64'(exp_resp_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
